// File: rtl/vga_ball_sequencer.sv
// rtl/vga_ball_sequencer.sv - host pass-through plus frame-driven bouncing-height animator for vga_ball
module vga_ball_sequencer #(
    parameter logic [7:0] HMIN        = 8'd0,
    parameter logic [7:0] HMAX        = 8'd239,
    parameter logic [7:0] STEP        = 8'd2,
    parameter logic [7:0] FRAME_DIV   = 8'd1,
    parameter logic [7:0] INIT_HEIGHT = 8'd120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       host_chipselect,
    input  logic       host_write,
    input  logic [2:0] host_address,
    input  logic [7:0] host_writedata,
    input  logic       vga_vs,
    output logic       vb_chipselect,
    output logic       vb_write,
    output logic [2:0] vb_address,
    output logic [7:0] vb_writedata,
    output logic [7:0] anim_height,
    output logic       anim_dir
);

    typedef enum logic [1:0] {IDLE, WAIT_VS, COMPUTE, ISSUE} state_t;

    localparam logic [7:0] DIV_LAST = (FRAME_DIV == 8'd0) ? 8'd0 : FRAME_DIV - 8'd1;

    state_t     state, state_nx;
    logic       enable;
    logic       vs_q;
    logic [7:0] frame_cnt;

    logic       host_acc, host_fwd, host_h, host_ctl, host_dis;
    logic       frame_evt, anim_issue;
    logic       vb_cs_d, vb_we_d;
    logic [2:0] vb_addr_d;
    logic [7:0] vb_data_d;
    logic [8:0] h_up, h_floor;
    logic [7:0] height_nx;
    logic       dir_nx;

    assign host_acc  = host_chipselect & host_write;
    assign host_fwd  = host_acc & ~host_address[2];
    assign host_h    = host_acc & (host_address == 3'd3);
    assign host_ctl  = host_acc & (host_address == 3'd4);
    assign host_dis  = host_ctl & ~host_writedata[0];
    assign frame_evt = vs_q & ~vga_vs;

    // 9-bit intermediates keep the bounds comparison free of wraparound
    assign h_up    = {1'b0, anim_height} + {1'b0, STEP};
    assign h_floor = {1'b0, HMIN} + {1'b0, STEP};

    always_comb begin
        height_nx = anim_height;
        dir_nx    = anim_dir;
        if (!anim_dir) begin
            if (h_up >= {1'b0, HMAX}) begin
                height_nx = HMAX;
                dir_nx    = 1'b1;
            end else begin
                height_nx = h_up[7:0];
            end
        end else begin
            if ({1'b0, anim_height} <= h_floor) begin
                height_nx = HMIN;
                dir_nx    = 1'b0;
            end else begin
                height_nx = anim_height - STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = WAIT_VS;
            WAIT_VS: if (frame_evt && frame_cnt == DIV_LAST) state_nx = COMPUTE;
            COMPUTE: state_nx = host_h ? WAIT_VS : ISSUE;
            // Any host access holds the animator write back; a host height write supersedes it
            ISSUE:   if (host_h || !host_acc) state_nx = WAIT_VS;
            default: state_nx = IDLE;
        endcase
        if (host_dis) state_nx = IDLE;
    end

    always_comb begin
        anim_issue = (state == ISSUE) && !host_acc;
        vb_cs_d    = 1'b0;
        vb_we_d    = 1'b0;
        vb_addr_d  = 3'd0;
        vb_data_d  = 8'd0;
        if (host_fwd) begin
            vb_cs_d   = 1'b1;
            vb_we_d   = 1'b1;
            vb_addr_d = host_address;
            vb_data_d = host_writedata;
        end else if (anim_issue) begin
            vb_cs_d   = 1'b1;
            vb_we_d   = 1'b1;
            vb_addr_d = 3'd3;
            vb_data_d = anim_height;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vb_chipselect <= 1'b0;
            vb_write      <= 1'b0;
            vb_address    <= 3'd0;
            vb_writedata  <= 8'd0;
            anim_height   <= INIT_HEIGHT;
            anim_dir      <= 1'b0;
            enable        <= 1'b0;
            frame_cnt     <= 8'd0;
            vs_q          <= 1'b1;
        end else begin
            vb_chipselect <= vb_cs_d;
            vb_write      <= vb_we_d;
            vb_address    <= vb_addr_d;
            vb_writedata  <= vb_data_d;
            vs_q          <= vga_vs;

            if (host_h) begin
                anim_height <= host_writedata;
            end else if (state == COMPUTE) begin
                anim_height <= height_nx;
            end

            if (host_ctl) begin
                anim_dir <= host_writedata[1];
                enable   <= host_writedata[0];
            end else if (state == COMPUTE) begin
                anim_dir <= dir_nx;
            end

            if (host_dis) begin
                frame_cnt <= 8'd0;
            end else if (state == WAIT_VS && frame_evt) begin
                frame_cnt <= (frame_cnt == DIV_LAST) ? 8'd0 : frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_ball_sequencer.sv
// tb/tb_vga_ball_sequencer.sv - scoreboard bench for vga_ball_sequencer (FRAME_DIV 1 and 3 side by side)
module tb_vga_ball_sequencer;

    localparam int HMIN = 0;
    localparam int HMAX = 239;
    localparam int STEP = 2;
    localparam int INIT = 120;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       host_chipselect = 1'b0;
    logic       host_write = 1'b0;
    logic [2:0] host_address = 3'd0;
    logic [7:0] host_writedata = 8'd0;
    logic       vga_vs = 1'b1;

    logic       cs0, we0, dir0, cs1, we1, dir1;
    logic [2:0] addr0, addr1;
    logic [7:0] wd0, wd1, h0, h1;

    int tests = 0;
    int fails = 0;

    wr_t q0[$];
    wr_t q1[$];
    int  mh[2], md[2], mf[2], men;
    int  mdiv[2] = '{1, 3};

    always #5 clk = ~clk;

    vga_ball_sequencer #(.FRAME_DIV(8'd1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .host_chipselect(host_chipselect), .host_write(host_write),
        .host_address(host_address), .host_writedata(host_writedata),
        .vga_vs(vga_vs),
        .vb_chipselect(cs0), .vb_write(we0), .vb_address(addr0), .vb_writedata(wd0),
        .anim_height(h0), .anim_dir(dir0)
    );

    vga_ball_sequencer #(.FRAME_DIV(8'd3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .host_chipselect(host_chipselect), .host_write(host_write),
        .host_address(host_address), .host_writedata(host_writedata),
        .vga_vs(vga_vs),
        .vb_chipselect(cs1), .vb_write(we1), .vb_address(addr1), .vb_writedata(wd1),
        .anim_height(h1), .anim_dir(dir1)
    );

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (we0 === 1'b1) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL div1 unexpected write: addr %0d data %0d expected none", addr0, wd0);
            end else begin
                e = q0.pop_front();
                chk("div1 vb_address", 16'(addr0), 16'(e.a));
                chk("div1 vb_writedata", 16'(wd0), 16'(e.d));
                chk("div1 vb_chipselect", 16'(cs0), 16'd1);
            end
        end
        if (we1 === 1'b1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL div3 unexpected write: addr %0d data %0d expected none", addr1, wd1);
            end else begin
                e = q1.pop_front();
                chk("div3 vb_address", 16'(addr1), 16'(e.a));
                chk("div3 vb_writedata", 16'(wd1), 16'(e.d));
                chk("div3 vb_chipselect", 16'(cs1), 16'd1);
            end
        end
    end

    function automatic void push(int k, int a, int d);
        wr_t w;
        w.a = a[2:0];
        w.d = d[7:0];
        if (k == 0) q0.push_back(w);
        else        q1.push_back(w);
    endfunction

    // Bounce rule: clamp at the limits and reverse there
    function automatic void m_compute(int k);
        if (md[k] == 0) begin
            if (mh[k] + STEP >= HMAX) begin mh[k] = HMAX; md[k] = 1; end
            else mh[k] = mh[k] + STEP;
        end else begin
            if (mh[k] <= HMIN + STEP) begin mh[k] = HMIN; md[k] = 0; end
            else mh[k] = mh[k] - STEP;
        end
    endfunction

    function automatic void model_op(bit frm, bit host, int a, int d);
        bit pend[2];
        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0;
            if (frm && men != 0) begin
                mf[k]++;
                if (mf[k] == mdiv[k]) begin
                    mf[k] = 0;
                    m_compute(k);
                    pend[k] = 1'b1;
                end
            end
            if (host) begin
                if (a <= 3) push(k, a, d);
                if (a == 3) begin mh[k] = d; pend[k] = 1'b0; end
                if (a == 4) begin
                    md[k] = d[1];
                    if (d[0] == 1'b0) begin pend[k] = 1'b0; mf[k] = 0; end
                end
            end
            if (pend[k]) push(k, 3, mh[k]);
        end
        if (host && a == 4) men = d[0];
    endfunction

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_drive(int a, int d);
        host_chipselect = 1'b1;
        host_write      = 1'b1;
        host_address    = a[2:0];
        host_writedata  = d[7:0];
        idle(1);
        host_chipselect = 1'b0;
        host_write      = 1'b0;
        host_address    = 3'd0;
        host_writedata  = 8'd0;
    endtask

    task automatic check_status();
        chk("div1 anim_height", 16'(h0), 16'(mh[0]));
        chk("div1 anim_dir", 16'(dir0), 16'(md[0]));
        chk("div3 anim_height", 16'(h1), 16'(mh[1]));
        chk("div3 anim_dir", 16'(dir1), 16'(md[1]));
    endtask

    task automatic op_host(int a, int d);
        host_drive(a, d);
        model_op(1'b0, 1'b1, a, d);
        idle(6);
        check_status();
    endtask

    // Host access, when requested, lands in the cycle the animator sits in ISSUE
    task automatic op_frame(bit coll, int a, int d);
        vga_vs = 1'b0;
        idle(1);
        vga_vs = 1'b1;
        idle(1);
        if (coll) host_drive(a, d);
        model_op(1'b1, coll, a, d);
        idle(8);
        check_status();
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, " div1 vb_write"}, 16'(we0), 16'd0);
        chk({tag, " div1 vb_chipselect"}, 16'(cs0), 16'd0);
        chk({tag, " div1 vb_address"}, 16'(addr0), 16'd0);
        chk({tag, " div1 vb_writedata"}, 16'(wd0), 16'd0);
        chk({tag, " div3 vb_write"}, 16'(we1), 16'd0);
        chk({tag, " div1 anim_height"}, 16'(h0), 16'(INIT));
        chk({tag, " div1 anim_dir"}, 16'(dir0), 16'd0);
        chk({tag, " div3 anim_height"}, 16'(h1), 16'(INIT));
    endtask

    task automatic op_reset();
        vga_vs = 1'b0;
        idle(1);
        vga_vs = 1'b1;
        idle(1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        idle(2);
        reset_n = 1'b1;
        mh = '{INIT, INIT};
        md = '{0, 0};
        mf = '{0, 0};
        men = 0;
        idle(6);
        check_status();
    endtask

    initial begin
        int kind, a, d;
        mh = '{INIT, INIT};
        md = '{0, 0};
        mf = '{0, 0};
        men = 0;
        idle(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        idle(2);

        op_host(0, 8'h55);
        op_host(4, 8'h01);
        repeat (3) op_frame(1'b0, 0, 0);
        op_host(3, 238);
        repeat (2) op_frame(1'b0, 0, 0);
        op_frame(1'b1, 2, 8'hA7);
        op_host(4, 8'h01);
        op_frame(1'b1, 3, 8'h10);
        op_frame(1'b0, 0, 0);
        repeat (6) op_frame(1'b0, 0, 0);
        op_reset();
        op_host(4, 8'h01);
        op_frame(1'b1, 4, 8'h00);
        op_host(4, 8'h01);
        op_frame(1'b1, 6, 8'h33);
        op_host(3, 8'd1);
        op_host(4, 8'h03);
        op_frame(1'b0, 0, 0);

        for (int i = 0; i < 120; i++) begin
            kind = $urandom_range(0, 19);
            a    = $urandom_range(0, 7);
            d    = $urandom_range(0, 255);
            if (a == 4) d = (d & 8'h02) | (($urandom_range(0, 3) != 0) ? 1 : 0);
            if (kind < 6)       op_host(a, d);
            else if (kind < 15) op_frame(1'b0, 0, 0);
            else if (kind < 19) op_frame(1'b1, a, d);
            else begin
                op_reset();
                op_host(4, 1 | ($urandom_range(0, 1) << 1));
            end
        end

        idle(4);
        chk("div1 queue drained", 16'(q0.size()), 16'd0);
        chk("div3 queue drained", 16'(q1.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
